// File: rtl/memory_control.sv
// Two-CPU coherent memory controller: arbitrates cache requests, snoops the peer cache and drives RAM.
// Define MEMCTRL_C2C_EN to forward dirty snooped data directly to the requester (else re-read from RAM).
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR (only ACCESS completes a transfer).

module memory_control #(
  parameter int CPUS = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  input  logic [CPUS-1:0]       ccwrite,
  input  logic [CPUS-1:0]       cctrans,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  output logic                  ramREN,
  output logic                  ramWEN
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    IFETCH,
    WB,
    SNOOP,
    C2C,
    MEMRD
  } state_t;

  state_t state, next;
  logic   last_grant, last_grant_n;
  logic   req, req_n;
  logic   snp, snp_n;
  logic   access;

  // On a tie the CPU that is not named by the last-grant bit wins.
  function automatic logic pick(input logic [1:0] strobes, input logic last);
    if (&strobes) return ~last;
    return strobes[1];
  endfunction

  assign access = (ramstate == RAM_ACCESS);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      req        <= 1'b0;
      snp        <= 1'b0;
    end else begin
      state      <= next;
      last_grant <= last_grant_n;
      req        <= req_n;
      snp        <= snp_n;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    next         = state;
    last_grant_n = last_grant;
    req_n        = req;
    snp_n        = snp;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = '1;
    dwait        = '1;
    iload        = '0;
    dload        = '0;
    ccwait       = '0;
    ccinv        = '0;
    ccsnoopaddr  = '0;

    case (state)
      IDLE: begin
        if ((|iREN) || (|dREN) || (|dWEN)) next = ARB;
      end

      ARB: begin
        if (|dWEN) begin
          req_n = pick(dWEN, last_grant);
          next  = WB;
        end else if (|dREN) begin
          req_n = pick(dREN, last_grant);
          next  = SNOOP;
        end else if (|iREN) begin
          req_n = pick(iREN, last_grant);
          next  = IFETCH;
        end else begin
          next  = IDLE;
        end
        snp_n = ~req_n;
      end

      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[req];
        iload[req] = ramload;
        if (access) begin
          iwait[req]   = 1'b0;
          last_grant_n = ~last_grant;
          next         = IDLE;
        end
      end

      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req];
        ramstore = dstore[req];
        if (access) begin
          dwait[req]   = 1'b0;
          last_grant_n = ~last_grant;
          next         = IDLE;
        end
      end

      // Single-cycle snoop; the peer answers on this edge with ccwrite/cctrans.
      SNOOP: begin
        ccwait[snp]      = 1'b1;
        ccsnoopaddr[snp] = daddr[req];
        ccinv[snp]       = ccwrite[req];
        next             = (ccwrite[snp] && cctrans[snp]) ? C2C : MEMRD;
      end

      // Peer holds the line dirty: write it back before the requester is served.
      C2C: begin
        ccwait[snp] = 1'b1;
        ramWEN      = 1'b1;
        ramaddr     = daddr[snp];
        ramstore    = dstore[snp];
`ifdef MEMCTRL_C2C_EN
        dload[req]  = dstore[snp];
        if (access) begin
          dwait[req]   = 1'b0;
          dwait[snp]   = 1'b0;
          last_grant_n = ~last_grant;
          next         = IDLE;
        end
`else
        if (access) begin
          dwait[snp] = 1'b0;
          next       = MEMRD;
        end
`endif
      end

      MEMRD: begin
        ccwait[snp] = 1'b1;
        ramREN      = 1'b1;
        ramaddr     = daddr[req];
        dload[req]  = ramload;
        if (access) begin
          dwait[req]   = 1'b0;
          last_grant_n = ~last_grant;
          next         = IDLE;
        end
      end

      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control: behavioural RAM with programmable BUSY latency and hand-derived expectations.
// Expectations follow MEMCTRL_C2C_EN when it is defined for the build.

module tb_memory_control;

  localparam logic [1:0] R_FREE   = 2'd0;
  localparam logic [1:0] R_BUSY   = 2'd1;
  localparam logic [1:0] R_ACCESS = 2'd2;
  localparam logic [1:0] R_ERROR  = 2'd3;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic [31:0]      ramload, ramaddr, ramstore;
  logic [1:0]       ramstate;
  logic             ramREN, ramWEN;

  int total = 0;
  int bad   = 0;
  int cyc;
  int cyc2;

  always #5 CLK = ~CLK;

  memory_control #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramload(ramload), .ramstate(ramstate),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN)
  );

  // RAM model: answers BUSY (or ERROR) for busy_n cycles of a held strobe, then one ACCESS cycle.
  logic [31:0] mem [0:255];
  int          ram_cnt;
  int          busy_n  = 2;
  logic        use_err = 1'b0;
  logic        pre_en  = 1'b0;
  logic [31:0] pre_addr, pre_data;

  always_comb begin
    if (!(ramREN || ramWEN))  ramstate = R_FREE;
    else if (ram_cnt >= busy_n) ramstate = R_ACCESS;
    else                      ramstate = use_err ? R_ERROR : R_BUSY;
  end

  assign ramload = mem[ramaddr[9:2]];

  always @(posedge CLK) begin
    if (pre_en) mem[pre_addr[9:2]] <= pre_data;
    if (ramREN || ramWEN) begin
      if (ramstate == R_ACCESS) begin
        ram_cnt <= 0;
        if (ramWEN) mem[ramaddr[9:2]] <= ramstore;
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else begin
      ram_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  logic mon = 1'b0;
  always @(negedge CLK) if (mon) check("ram_excl", 32'(ramREN & ramWEN), 32'h0);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  // Counts negedges (inclusive) until the selected wait drops; bounded.
  task automatic wait_low(input string tag, input logic is_d, input int cpu, output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      cycles++;
      if ((is_d ? dwait[cpu] : iwait[cpu]) == 1'b0) return;
    end
    check({tag, "_timeout"}, 32'(is_d ? dwait[cpu] : iwait[cpu]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    pre_addr = '0; pre_data = '0;

    preload(32'h100, 32'hDEADBEEF);
    preload(32'h200, 32'hAAAA5555);
    preload(32'h300, 32'h0BADF00D);
    @(negedge CLK);
    check("rst_ramREN", 32'(ramREN), 32'h0);
    check("rst_ramWEN", 32'(ramWEN), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_ccwait", 32'(ccwait), 32'h0);
    check("rst_ccinv", 32'(ccinv), 32'h0);
    check("rst_iload", iload[0] | iload[1], 32'h0);
    check("rst_dload", dload[0] | dload[1], 32'h0);
    check("rst_snpaddr", ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
    tick();
    RST = 1'b0;
    mon = 1'b1;

    // Instruction fetch, two BUSY cycles then ACCESS.
    tick();
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    wait_low("if_wait", 1'b0, 0, cyc);
    check("if_latency", 32'(cyc), 32'd5);
    check("if_iload0", iload[0], 32'hDEADBEEF);
    check("if_iload1", iload[1], 32'h0);
    check("if_ramaddr", ramaddr, 32'h100);
    check("if_ramREN", 32'(ramREN), 32'h1);
    tick();
    iREN[0] = 1'b0;
    @(negedge CLK);
    check("if_pulse_once", 32'(iwait), 32'h3);
    check("if_strobe_off", 32'(ramREN), 32'h0);

    // Writeback while the RAM reports ERROR instead of BUSY.
    tick();
    use_err = 1'b1;
    dWEN[0] = 1'b1; daddr[0] = 32'h300; dstore[0] = 32'hCAFEF00D;
    wait_low("wb_wait", 1'b1, 0, cyc);
    check("wb_latency", 32'(cyc), 32'd5);
    check("wb_ramWEN", 32'(ramWEN), 32'h1);
    check("wb_ramaddr", ramaddr, 32'h300);
    check("wb_ramstore", ramstore, 32'hCAFEF00D);
    tick();
    dWEN[0] = 1'b0; use_err = 1'b0;
    check("wb_last_grant", 32'(dut.last_grant), 32'h0);

    // Simultaneous reads, last-grant 0: CPU1 first, then CPU0.
    tick();
    dREN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h100;
    repeat (3) @(negedge CLK);
    check("rr1_ccwait", 32'(ccwait), 32'h1);
    check("rr1_snpaddr", ccsnoopaddr[0], 32'h100);
    check("rr1_ccinv", 32'(ccinv), 32'h0);
    wait_low("rr1_wait", 1'b1, 1, cyc);
    check("rr1_latency", 32'(cyc + 3), 32'd6);
    check("rr1_dwait", 32'(dwait), 32'h1);
    check("rr1_dload1", dload[1], 32'hDEADBEEF);
    check("rr1_dload0", dload[0], 32'h0);
    tick();
    dREN[1] = 1'b0;
    check("rr1_last_grant", 32'(dut.last_grant), 32'h1);
    repeat (3) @(negedge CLK);
    check("rr2_ccwait", 32'(ccwait), 32'h2);
    check("rr2_snpaddr", ccsnoopaddr[1], 32'h300);
    wait_low("rr2_wait", 1'b1, 0, cyc);
    check("rr2_latency", 32'(cyc + 3), 32'd6);
    check("rr2_dload0", dload[0], 32'hCAFEF00D);
    check("rr2_dload1", dload[1], 32'h0);
    tick();
    dREN[0] = 1'b0;
    check("rr2_last_grant", 32'(dut.last_grant), 32'h0);

    // CPU1 writeback beats CPU0 instruction fetch.
    tick();
    dWEN[1] = 1'b1; daddr[1] = 32'h140; dstore[1] = 32'h11112222;
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    wait_low("mix_wb_wait", 1'b1, 1, cyc);
    check("mix_wb_latency", 32'(cyc), 32'd5);
    check("mix_iwait_held", 32'(iwait), 32'h3);
    check("mix_wb_ramaddr", ramaddr, 32'h140);
    check("mix_wb_ramstore", ramstore, 32'h11112222);
    tick();
    dWEN[1] = 1'b0;
    wait_low("mix_if_wait", 1'b0, 0, cyc);
    check("mix_if_latency", 32'(cyc), 32'd5);
    check("mix_if_iload0", iload[0], 32'hDEADBEEF);
    tick();
    iREN[0] = 1'b0;

    // Coherent read of a line held dirty by CPU1.
    tick();
    dREN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h200;
    ccwrite[1] = 1'b1; cctrans[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'h12345678;
    repeat (3) @(negedge CLK);
    check("c2c_ccinv", 32'(ccinv), 32'h2);
    check("c2c_snp_ccwait", 32'(ccwait), 32'h2);
    check("c2c_snpaddr", ccsnoopaddr[1], 32'h200);
    check("c2c_snpaddr0", ccsnoopaddr[0], 32'h0);
    @(negedge CLK);
    check("c2c_ramWEN", 32'(ramWEN), 32'h1);
    check("c2c_ramaddr", ramaddr, 32'h200);
    check("c2c_ramstore", ramstore, 32'h12345678);
    check("c2c_ccinv_off", 32'(ccinv), 32'h0);
    wait_low("c2c_wait", 1'b1, 1, cyc);
    check("c2c_wb_latency", 32'(cyc + 4), 32'd6);
`ifdef MEMCTRL_C2C_EN
    check("c2c_dwait_both", 32'(dwait), 32'h0);
    check("c2c_dload0", dload[0], 32'h12345678);
    check("c2c_dload1", dload[1], 32'h0);
`else
    check("c2c_dwait_peer", 32'(dwait), 32'h1);
    wait_low("c2c_rd_wait", 1'b1, 0, cyc2);
    check("c2c_rd_latency", 32'(cyc2), 32'd3);
    check("c2c_rd_dwait", 32'(dwait), 32'h2);
    check("c2c_rd_ramREN", 32'(ramREN), 32'h1);
    check("c2c_rd_ramaddr", ramaddr, 32'h200);
    check("c2c_rd_ccwait", 32'(ccwait), 32'h2);
    check("c2c_rd_dload0", dload[0], 32'h12345678);
`endif
    tick();
    dREN[0] = 1'b0; ccwrite = '0; cctrans = '0;

    // Reset asserted during a RAM read.
    tick();
    busy_n  = 5;
    dREN[1] = 1'b1; daddr[1] = 32'h300;
    repeat (4) @(negedge CLK);
    check("rst_pre_ramREN", 32'(ramREN), 32'h1);
    check("rst_pre_ramaddr", ramaddr, 32'h300);
    #1;
    RST = 1'b1;
    #1;
    check("rst_mid_ramREN", 32'(ramREN), 32'h0);
    check("rst_mid_ramaddr", ramaddr, 32'h0);
    check("rst_mid_dwait", 32'(dwait), 32'h3);
    check("rst_mid_iwait", 32'(iwait), 32'h3);
    check("rst_mid_ccwait", 32'(ccwait), 32'h0);
    check("rst_mid_dload", dload[1], 32'h0);
    repeat (2) begin
      @(negedge CLK);
      check("rst_hold_dwait", 32'(dwait), 32'h3);
    end
    check("rst_last_grant", 32'(dut.last_grant), 32'h0);
    tick();
    RST = 1'b0; dREN[1] = 1'b0; busy_n = 2;
    repeat (3) begin
      @(negedge CLK);
      check("post_rst_dwait", 32'(dwait), 32'h3);
      check("post_rst_ramREN", 32'(ramREN), 32'h0);
    end

    mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
